if_sequencer: RTL
=================

IF_SEQUENCER -- requirements
Module: if_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00003000, giving the first fetch address after reset.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port stall_in, input, 1: decode-stage stall from the hazard unit; when 1, the D-stage outputs hold.
REQ-005 Port redirect, input, 1: decode-stage branch/jump taken (PCSrcD).
REQ-006 Port redirect_pc, input, 32: branch/jump target (NPCD), sampled when redirect=1.
REQ-007 Port imem_req, output, 1: instruction-memory request.
REQ-008 Port imem_addr, output, 32: fetch address; equals internal pc.
REQ-009 Port imem_ack, input, 1: one-cycle data-valid pulse, 0..N cycles after request.
REQ-010 Port imem_rdata, input, 32: instruction word, valid when imem_ack=1.
REQ-011 Port instr_d, output, 32: registered instruction to decode (InstrD).
REQ-012 Port pcplus4_d, output, 32: registered PC+4 of instr_d (PCplus4D).
REQ-013 Port valid_d, output, 1: instr_d holds a real instruction (0 = bubble).
REQ-014 Port stall_f, output, 1: fetch not advancing this cycle; 1 when state=HOLD, or state=FETCH and imem_ack=0.

Function
REQ-015 States SHALL be FETCH (imem_req=1) and HOLD (imem_req=0); imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-016 FETCH, ack=1, stall_in=0: instr_d<=imem_rdata, pcplus4_d<=pc+4, valid_d<=1, pc advances (REQ-020), stay FETCH.
REQ-017 FETCH, ack=1, stall_in=1: buf<=imem_rdata, buf_pc4<=pc+4, pc advances, D outputs hold, next state HOLD.
REQ-018 FETCH, ack=0: stall_in=0 -> instr_d<=0, valid_d<=0, pcplus4_d holds; stall_in=1 -> D outputs hold; pc holds.
REQ-019 HOLD: stall_in=1 -> hold everything; stall_in=0 -> instr_d<=buf, pcplus4_d<=buf_pc4, valid_d<=1, next state FETCH.
REQ-020 pc advance: next pc = redirect_pc if redirect=1 this cycle; else pend_tgt if pend=1; else pc+4 (32-bit wrap, no carry out); pend cleared on advance.
REQ-021 redirect=1 in a cycle with no pc advance: pend<=1, pend_tgt<=redirect_pc; a later redirect overwrites pend_tgt (latest wins).
REQ-022 The in-flight fetch when redirect arrives is the delay slot and SHALL NOT be squashed; the target becomes the fetch following it.
REQ-023 redirect held high across several stalled cycles with the same target SHALL be idempotent.
REQ-024 imem_ack while in HOLD SHALL be ignored (protocol violation; no state change).
REQ-025 Back-to-back zero-wait acks SHALL give one instruction per cycle, stall_f=0 throughout.

Reset
REQ-026 reset=0 SHALL immediately force: state=FETCH, pc=RESET_PC, pend=0, pend_tgt=0, buf=0, buf_pc4=0, instr_d=0, pcplus4_d=RESET_PC+4, valid_d=0.
REQ-027 Reset asserted mid-fetch SHALL abandon the request; instruction memory is reset by the same signal; the first request after release is to RESET_PC.
REQ-028 imem_req SHALL be 1 in the first cycle after reset release.

Verification
REQ-029 Zero-wait stream from reset, no stalls -> imem_addr 0x3000,0x3004,0x3008; instr_d follows one cycle later, valid_d=1, pcplus4_d 0x3004,0x3008,0x300C.
REQ-030 Ack delayed 3 cycles at 0x3000 -> imem_addr stable 0x3000 for 4 cycles, stall_f=1 for 3, valid_d=0 bubbles, then instr_d=rdata, pcplus4_d=0x3004.
REQ-031 Ack with stall_in=1 for 2 cycles -> HOLD, imem_req=0, D outputs unchanged; stall_in drop -> buffered word appears, fetch resumes at pc+4.
REQ-032 redirect=1, target 0x3100, while fetching 0x3008 (ack 2 cycles later) -> 0x3008 delivered (delay slot), next imem_addr=0x3100.
REQ-033 Two redirects (0x3100 then 0x3200) before one ack -> next fetch 0x3200; redirect coincident with ack -> next fetch equals that cycle's redirect_pc.
REQ-034 reset=0 mid-wait at 0x3010 -> outputs reset asynchronously; after release imem_addr=0x3000, pcplus4_d=0x3004, valid_d=0.

Source files
------------

// File: rtl/if_sequencer.sv
// Fetch sequencer: drives instruction-memory requests and registers fetched words into the decode stage.
// Latency: one cycle from imem_ack to instr_d; a stalled word is parked in a one-entry buffer until stall_in drops.
module if_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        stall_f
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_tgt;
  logic [31:0] ibuf;
  logic [31:0] ibuf_pc4;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4  = pc + 32'd4;
  // A same-cycle redirect beats an older pending target.
  assign next_pc   = redirect ? redirect_pc : (pend ? pend_tgt : pc_plus4);
  assign imem_addr = pc;
  assign stall_f   = (state == HOLD) || !imem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      imem_req  <= 1'b1;
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_tgt  <= 32'd0;
      ibuf      <= 32'd0;
      ibuf_pc4  <= 32'd0;
      instr_d   <= 32'd0;
      pcplus4_d <= RESET_PC + 32'd4;
      valid_d   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            pc   <= next_pc;
            pend <= 1'b0;
            if (stall_in) begin
              ibuf     <= imem_rdata;
              ibuf_pc4 <= pc_plus4;
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              instr_d   <= imem_rdata;
              pcplus4_d <= pc_plus4;
              valid_d   <= 1'b1;
            end
          end else begin
            if (redirect) begin
              pend     <= 1'b1;
              pend_tgt <= redirect_pc;
            end
            if (!stall_in) begin
              instr_d <= 32'd0;
              valid_d <= 1'b0;
            end
          end
        end
        HOLD: begin
          // The fetched word is already parked, so any ack seen here is spurious.
          if (redirect) begin
            pend     <= 1'b1;
            pend_tgt <= redirect_pc;
          end
          if (!stall_in) begin
            instr_d   <= ibuf;
            pcplus4_d <= ibuf_pc4;
            valid_d   <= 1'b1;
            state     <= FETCH;
            imem_req  <= 1'b1;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule
